// File: rtl/i8088_bus_ctrl_if.sv
// i8088_bus_ctrl_if: internal level req/ack bus between the i8088 bus controller and memory/IO
interface i8088_bus_ctrl_if;
  logic [19:0] bus_addr;
  logic        bus_io;
  logic        bus_rd;
  logic        bus_wr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_ack;
  logic        bus_err;
  modport master (output bus_addr, bus_io, bus_rd, bus_wr, bus_wdata, bus_err, input bus_rdata, bus_ack);
  modport slave  (input bus_addr, bus_io, bus_rd, bus_wr, bus_wdata, bus_err, output bus_rdata, bus_ack);
endinterface

// File: rtl/i8088_bus_ctrl.sv
// i8088_bus_ctrl: clocks/resets the i8088 and turns its bus cycles into internal req/ack transactions
module i8088_bus_ctrl #(
  parameter int CLKDIV     = 6,
  parameter int RST_CYCLES = 16,
  parameter int TIMEOUT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        clkcpu,
  output logic        cpu_rst,
  input  logic [7:0]  ad_in,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  input  logic [11:0] a,
  input  logic        ale,
  input  logic        den_n,
  input  logic        io_m_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        dt_r_n,
  input  logic        ss0,
  output logic        intr,
  input  logic        irq,
  i8088_bus_ctrl_if.master bus,
  output logic [2:0]  cyc_status
);
  localparam int CW = $clog2(CLKDIV);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, RD_REQ, RD_HOLD, WR_REQ} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rcnt;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic [19:0] addr, addr_nx;
  logic [7:0] wdata_r, wdata_nx, ad_out_nx;
  logic io_nx, rd_nx, wr_nx, err_nx;
  logic rd_s1, rd_s, rd_d, wr_s1, wr_s, wr_d, rd_fall, wr_rise, tout, wrap;
  assign wrap    = cnt == CW'(CLKDIV - 1);
  assign rd_fall = rd_d & ~rd_s;
  assign wr_rise = ~wr_d & wr_s;
  assign tout    = tcnt == TW'(TIMEOUT - 1);
  always_comb begin
    state_nx  = state;
    tcnt_nx   = tcnt;
    addr_nx   = bus.bus_addr;
    io_nx     = bus.bus_io;
    rd_nx     = bus.bus_rd;
    wr_nx     = bus.bus_wr;
    wdata_nx  = bus.bus_wdata;
    err_nx    = 1'b0;
    ad_out_nx = ad_out;
    case (state)
      IDLE: begin
        tcnt_nx = '0;
        if (rd_fall || wr_rise) begin
          addr_nx = addr;
          io_nx   = cyc_status[2];
        end
        // A simultaneous read and write start favours the read
        if (rd_fall) begin
          state_nx = RD_REQ;
          rd_nx    = 1'b1;
        end else if (wr_rise) begin
          state_nx = WR_REQ;
          wr_nx    = 1'b1;
          wdata_nx = wdata_r;
        end
      end
      RD_REQ: begin
        tcnt_nx = tcnt + 1'b1;
        if (bus.bus_ack || tout) begin
          state_nx  = RD_HOLD;
          rd_nx     = 1'b0;
          ad_out_nx = bus.bus_ack ? bus.bus_rdata : 8'hFF;
          err_nx    = ~bus.bus_ack;
        end
      end
      RD_HOLD: state_nx = rd_s ? IDLE : RD_HOLD;
      WR_REQ: begin
        tcnt_nx = tcnt + 1'b1;
        if (bus.bus_ack || tout) begin
          state_nx = IDLE;
          wr_nx    = 1'b0;
          err_nx   = ~bus.bus_ack;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      clkcpu        <= 1'b0;
      rcnt          <= '0;
      cpu_rst       <= 1'b1;
      intr          <= 1'b0;
      addr          <= '0;
      cyc_status    <= '0;
      wdata_r       <= '0;
      {rd_s1, rd_s, rd_d, wr_s1, wr_s, wr_d} <= '1;
      state         <= IDLE;
      tcnt          <= '0;
      ad_out        <= 8'hFF;
      ad_oe         <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_io    <= 1'b0;
      bus.bus_rd    <= 1'b0;
      bus.bus_wr    <= 1'b0;
      bus.bus_wdata <= '0;
      bus.bus_err   <= 1'b0;
    end else begin
      cnt    <= wrap ? '0 : cnt + 1'b1;
      clkcpu <= cnt < CW'(CLKDIV / 3);
      if (wrap && cpu_rst) begin
        rcnt <= rcnt + 1'b1;
        if (rcnt == RW'(RST_CYCLES - 1)) cpu_rst <= 1'b0;
      end
      intr <= irq & ~cpu_rst;
      if (ale) begin
        addr       <= {a, ad_in};
        cyc_status <= {io_m_n, dt_r_n, ss0};
      end
      if (!wr_n) wdata_r <= ad_in;
      {rd_s1, rd_s, rd_d} <= {rd_n, rd_s1, rd_s};
      {wr_s1, wr_s, wr_d} <= {wr_n, wr_s1, wr_s};
      state  <= state_nx;
      tcnt   <= tcnt_nx;
      ad_out <= ad_out_nx;
      ad_oe  <= (state == RD_REQ || state == RD_HOLD) & ~rd_n & ~den_n & ~dt_r_n;
      bus.bus_addr  <= addr_nx;
      bus.bus_io    <= io_nx;
      bus.bus_rd    <= rd_nx;
      bus.bus_wr    <= wr_nx;
      bus.bus_wdata <= wdata_nx;
      bus.bus_err   <= err_nx;
    end
  end
endmodule

// File: tb/tb_i8088_bus_ctrl.sv
// tb_i8088_bus_ctrl: directed vectors with hand-computed expectations for i8088_bus_ctrl
module tb_i8088_bus_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic clkcpu, cpu_rst, ad_oe, intr;
  logic [7:0] ad_in = 8'h00, ad_out;
  logic [11:0] a = 12'h000;
  logic ale = 0, den_n = 1, io_m_n = 0, rd_n = 1, wr_n = 1, dt_r_n = 1, ss0 = 0, irq = 1;
  logic [2:0] cyc_status;
  int n_vec = 0, n_bad = 0;
  i8088_bus_ctrl_if bus_if ();
  i8088_bus_ctrl dut (
    .clk(clk), .rst(rst), .clkcpu(clkcpu), .cpu_rst(cpu_rst), .ad_in(ad_in), .ad_out(ad_out),
    .ad_oe(ad_oe), .a(a), .ale(ale), .den_n(den_n), .io_m_n(io_m_n), .rd_n(rd_n), .wr_n(wr_n),
    .dt_r_n(dt_r_n), .ss0(ss0), .intr(intr), .irq(irq), .bus(bus_if), .cyc_status(cyc_status)
  );
  always #20 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    bus_if.bus_ack = 1'b0;
    bus_if.bus_rdata = 8'h00;
    tick();
    chk("rst_clkcpu", clkcpu, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_ad_oe", ad_oe, 0);
    chk("rst_ad_out", ad_out, 8'hFF);
    chk("rst_rd_wr_err", {bus_if.bus_rd, bus_if.bus_wr, bus_if.bus_err}, 0);
    chk("rst_addr", bus_if.bus_addr, 0);
    chk("rst_wdata", bus_if.bus_wdata, 0);
    chk("rst_intr", intr, 0);
    chk("rst_cyc_status", cyc_status, 0);
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk($sformatf("clkcpu_%0d", i), clkcpu, ((i - 1) % 6) < 2);
    end
    tick(95 - 12);
    chk("cpu_rst_95", cpu_rst, 1);
    chk("intr_in_reset", intr, 0);
    tick();
    chk("cpu_rst_96", cpu_rst, 0);
    chk("intr_96", intr, 0);
    tick();
    chk("intr_97", intr, 1);
    chk("clkcpu_97", clkcpu, 1);
    irq = 1'b0;
    tick(2);
    // memory read acknowledged one clk after bus_rd
    ale = 1; a = 12'hF00; ad_in = 8'h10; io_m_n = 0; dt_r_n = 0; ss0 = 1;
    tick();
    chk("rd_cyc_status", cyc_status, 3'b001);
    ale = 0; ad_in = 8'h00; rd_n = 0; den_n = 0;
    tick(2);
    chk("rd_not_yet", bus_if.bus_rd, 0);
    tick();
    chk("rd_bus_rd", bus_if.bus_rd, 1);
    chk("rd_addr", bus_if.bus_addr, 20'hF0010);
    chk("rd_io", bus_if.bus_io, 0);
    chk("rd_oe_early", ad_oe, 0);
    bus_if.bus_ack = 1; bus_if.bus_rdata = 8'hEA;
    tick();
    bus_if.bus_ack = 0;
    chk("rd_ad_out", ad_out, 8'hEA);
    chk("rd_drop", bus_if.bus_rd, 0);
    chk("rd_oe", ad_oe, 1);
    tick();
    chk("rd_oe_hold", ad_oe, 1);
    rd_n = 1;
    tick();
    chk("rd_oe_release", ad_oe, 0);
    den_n = 1; dt_r_n = 1;
    tick(3);
    chk("rd_ad_out_held", ad_out, 8'hEA);
    // IO write
    ale = 1; a = 12'h000; ad_in = 8'h80; io_m_n = 1; ss0 = 0;
    tick();
    chk("wr_cyc_status", cyc_status, 3'b110);
    ale = 0; ad_in = 8'h5A; wr_n = 0;
    tick(3);
    wr_n = 1; ad_in = 8'hFF;
    tick(2);
    chk("wr_not_yet", bus_if.bus_wr, 0);
    tick();
    chk("wr_bus_wr", bus_if.bus_wr, 1);
    chk("wr_io", bus_if.bus_io, 1);
    chk("wr_wdata", bus_if.bus_wdata, 8'h5A);
    chk("wr_addr", bus_if.bus_addr, 20'h00080);
    bus_if.bus_ack = 1;
    tick();
    bus_if.bus_ack = 0;
    chk("wr_drop", bus_if.bus_wr, 0);
    chk("wr_no_err", bus_if.bus_err, 0);
    tick(2);
    // read with no ack times out
    ale = 1; a = 12'h123; ad_in = 8'h45; io_m_n = 0; dt_r_n = 0;
    tick();
    ale = 0; rd_n = 0; den_n = 0;
    tick(3);
    chk("to_bus_rd", bus_if.bus_rd, 1);
    chk("to_addr", bus_if.bus_addr, 20'h12345);
    tick(3);
    chk("to_still_rd", {bus_if.bus_rd, bus_if.bus_err}, 2'b10);
    tick();
    chk("to_rd_drop", bus_if.bus_rd, 0);
    chk("to_err", bus_if.bus_err, 1);
    chk("to_ad_out", ad_out, 8'hFF);
    tick();
    chk("to_err_pulse", bus_if.bus_err, 0);
    chk("to_oe", ad_oe, 1);
    rd_n = 1; den_n = 1;
    tick(3);
    // ack while idle does nothing
    bus_if.bus_ack = 1; bus_if.bus_rdata = 8'h11;
    tick();
    bus_if.bus_ack = 0;
    chk("idle_ack", {bus_if.bus_rd, bus_if.bus_wr, bus_if.bus_err, ad_out}, {3'b000, 8'hFF});
    tick();
    // reset in the middle of a read
    rd_n = 0; den_n = 0;
    tick(3);
    chk("ab_bus_rd", bus_if.bus_rd, 1);
    tick();
    chk("ab_oe_before", ad_oe, 1);
    rst = 1;
    tick();
    chk("ab_bus_rd_drop", bus_if.bus_rd, 0);
    chk("ab_oe", ad_oe, 0);
    chk("ab_cpu_rst", cpu_rst, 1);
    chk("ab_clkcpu", clkcpu, 0);
    rst = 0; rd_n = 1; den_n = 1;
    tick(4);
    chk("ab_idle", {bus_if.bus_rd, bus_if.bus_err, ad_oe}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
